i2c_byte_monitor: RTL and testbench

Byte-level I2C receiver/monitor downstream of the SDA/SCL edge detectors and START/STOP detector. It consumes the one-cycle SCL rising-edge strobe, the START/STOP strobes and the synchronized SDA level. It deserializes each 9-bit frame (8 data bits MSB first plus ACK) and hands the byte to a consumer over a single-entry valid/ready buffer. It also flags slave-address hits, aborted frames and consumer overruns.

---
 rtl/i2c_byte_monitor_if.sv | 31 +++
 rtl/i2c_byte_monitor.sv | 141 ++++++++++++++
 tb/tb_i2c_byte_monitor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_monitor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_byte_monitor_if : bus bundle between bit-level front end and byte monitor
// Rev 1.0
// ---------------------------------------------------------------------------
interface i2c_byte_monitor_if;
    logic       sda;
    logic       scl_lohi;
    logic       sta;
    logic       sto;
    logic       rdy;
    logic       ovr_clr;
    logic [7:0] dat;
    logic       ack;
    logic       first;
    logic       vld;
    logic       addr_hit;
    logic       abrt;
    logic       ovr;

    modport master (
        output sda, scl_lohi, sta, sto, rdy, ovr_clr,
        input  dat, ack, first, vld, addr_hit, abrt, ovr
    );

    modport slave (
        input  sda, scl_lohi, sta, sto, rdy, ovr_clr,
        output dat, ack, first, vld, addr_hit, abrt, ovr
    );
endinterface
`default_nettype wire

// File: rtl/i2c_byte_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2c_byte_monitor : 9-bit I2C frame deserializer with single-entry output buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module i2c_byte_monitor #(
    parameter logic [6:0] ADDR     = 7'h50,
    parameter bit         MATCH_EN = 1'b1
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    i2c_byte_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACKB  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic       frst_q, frst_d;
    logic [7:0] dat_q, dat_d;
    logic       ack_q, ack_d;
    logic       first_q, first_d;
    logic       vld_q, vld_d;
    logic       addr_hit_q, addr_hit_d;
    logic       abrt_q, abrt_d;
    logic       ovr_q, ovr_d;
    logic       frm_done;
    logic       partial_frm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            sr_q       <= 8'd0;
            frst_q     <= 1'b0;
            dat_q      <= 8'd0;
            ack_q      <= 1'b0;
            first_q    <= 1'b0;
            vld_q      <= 1'b0;
            addr_hit_q <= 1'b0;
            abrt_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            frst_q     <= frst_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            first_q    <= first_d;
            vld_q      <= vld_d;
            addr_hit_q <= addr_hit_d;
            abrt_q     <= abrt_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        frst_d      = frst_q;
        dat_d       = dat_q;
        ack_d       = ack_q;
        first_d     = first_q;
        vld_d       = vld_q;
        addr_hit_d  = addr_hit_q;
        abrt_d      = 1'b0;
        ovr_d       = bus.ovr_clr ? 1'b0 : ovr_q;
        frm_done    = 1'b0;
        partial_frm = ((state_q == SHIFT) && (cnt_q != 4'd0)) || (state_q == ACKB);

        // START beats STOP beats the SCL sample; a coincident bit is lost
        if (bus.sta) begin
            state_d    = SHIFT;
            cnt_d      = 4'd0;
            frst_d     = 1'b1;
            addr_hit_d = 1'b0;
            abrt_d     = partial_frm;
        end else if (bus.sto) begin
            state_d    = IDLE;
            cnt_d      = 4'd0;
            addr_hit_d = 1'b0;
            abrt_d     = partial_frm;
        end else if (bus.scl_lohi) begin
            case (state_q)
                SHIFT: begin
                    sr_d  = {sr_q[6:0], bus.sda};
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d = ACKB;
                    end
                end
                ACKB: begin
                    frm_done = 1'b1;
                    if (!bus.sda) begin
                        state_d = SHIFT;
                        cnt_d   = 4'd0;
                        frst_d  = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: ;
            endcase
        end

        if (frm_done) begin
            if (!vld_q || bus.rdy) begin
                dat_d   = sr_q;
                ack_d   = ~bus.sda;
                first_d = frst_q;
                vld_d   = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
            // address compare runs even when the byte itself is dropped
            if (frst_q && MATCH_EN) begin
                addr_hit_d = (sr_q[7:1] == ADDR);
            end
        end else if (vld_q && bus.rdy) begin
            vld_d = 1'b0;
        end
    end

    assign bus.dat      = dat_q;
    assign bus.ack      = ack_q;
    assign bus.first    = first_q;
    assign bus.vld      = vld_q;
    assign bus.addr_hit = addr_hit_q;
    assign bus.abrt     = abrt_q;
    assign bus.ovr      = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2c_byte_monitor : directed self-checking bench for i2c_byte_monitor
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_i2c_byte_monitor;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    i2c_byte_monitor_if bus ();
    i2c_byte_monitor_if bus_nm ();

    // second instance with address matching disabled sees identical stimulus
    assign bus_nm.sda      = bus.sda;
    assign bus_nm.scl_lohi = bus.scl_lohi;
    assign bus_nm.sta      = bus.sta;
    assign bus_nm.sto      = bus.sto;
    assign bus_nm.rdy      = bus.rdy;
    assign bus_nm.ovr_clr  = bus.ovr_clr;

    i2c_byte_monitor #(.ADDR(7'h50), .MATCH_EN(1'b1)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    i2c_byte_monitor #(.ADDR(7'h50), .MATCH_EN(1'b0)) u_dut_nm (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_nm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.sda      = b;
        bus.scl_lohi = 1'b1;
        tick();
        bus.scl_lohi = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic nack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(nack);
    endtask

    task automatic do_sta();
        bus.sta = 1'b1;
        tick();
        bus.sta = 1'b0;
    endtask

    task automatic do_sto();
        bus.sto = 1'b1;
        tick();
        bus.sto = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dat"},      {24'd0, bus.dat}, 32'h00);
        chk({tag, ".ack"},      {31'd0, bus.ack}, 32'd0);
        chk({tag, ".first"},    {31'd0, bus.first}, 32'd0);
        chk({tag, ".vld"},      {31'd0, bus.vld}, 32'd0);
        chk({tag, ".addr_hit"}, {31'd0, bus.addr_hit}, 32'd0);
        chk({tag, ".abrt"},     {31'd0, bus.abrt}, 32'd0);
        chk({tag, ".ovr"},      {31'd0, bus.ovr}, 32'd0);
    endtask

    initial begin
        int vld_seen;
        bus.sda      = 1'b1;
        bus.scl_lohi = 1'b0;
        bus.sta      = 1'b0;
        bus.sto      = 1'b0;
        bus.rdy      = 1'b1;
        bus.ovr_clr  = 1'b0;
        rst_n        = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // address byte 0xA0 ACKed, rdy high
        do_sta();
        send_byte(8'hA0, 1'b0);
        chk("t1.vld",      {31'd0, bus.vld}, 32'd1);
        chk("t1.dat",      {24'd0, bus.dat}, 32'hA0);
        chk("t1.ack",      {31'd0, bus.ack}, 32'd1);
        chk("t1.first",    {31'd0, bus.first}, 32'd1);
        chk("t1.addr_hit", {31'd0, bus.addr_hit}, 32'd1);
        chk("nm.vld",      {31'd0, bus_nm.vld}, 32'd1);
        chk("nm.dat",      {24'd0, bus_nm.dat}, 32'hA0);
        chk("nm.first",    {31'd0, bus_nm.first}, 32'd1);
        chk("nm.addr_hit", {31'd0, bus_nm.addr_hit}, 32'd0);
        tick();
        chk("t1.vld_consumed", {31'd0, bus.vld}, 32'd0);

        // data byte 0x3C NACKed, then HOLD ignores further bits
        send_byte(8'h3C, 1'b1);
        chk("t2.dat",      {24'd0, bus.dat}, 32'h3C);
        chk("t2.ack",      {31'd0, bus.ack}, 32'd0);
        chk("t2.first",    {31'd0, bus.first}, 32'd0);
        chk("t2.addr_hit", {31'd0, bus.addr_hit}, 32'd1);
        vld_seen = 0;
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b0);
            if (bus.vld) vld_seen++;
        end
        chk("t2.hold_vld", vld_seen, 32'd0);
        do_sto();
        chk("t2.sto_addr_hit", {31'd0, bus.addr_hit}, 32'd0);
        chk("t2.sto_abrt",     {31'd0, bus.abrt}, 32'd0);

        // overrun with consumer stalled
        bus.rdy = 1'b0;
        do_sta();
        send_byte(8'h11, 1'b0);
        chk("t3.dat1", {24'd0, bus.dat}, 32'h11);
        chk("t3.vld1", {31'd0, bus.vld}, 32'd1);
        chk("t3.ovr1", {31'd0, bus.ovr}, 32'd0);
        send_byte(8'h22, 1'b0);
        chk("t3.dat2",  {24'd0, bus.dat}, 32'h11);
        chk("t3.first", {31'd0, bus.first}, 32'd1);
        chk("t3.ovr2",  {31'd0, bus.ovr}, 32'd1);
        bus.rdy = 1'b1;
        tick();
        bus.rdy = 1'b0;
        chk("t3.vld_pop", {31'd0, bus.vld}, 32'd0);
        chk("t3.ovr_sticky", {31'd0, bus.ovr}, 32'd1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("t3.ovr_clr", {31'd0, bus.ovr}, 32'd0);
        do_sto();
        chk("t3.sto_abrt", {31'd0, bus.abrt}, 32'd0);

        // partial frame aborted by repeated START
        bus.rdy = 1'b1;
        do_sta();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        do_sta();
        chk("t4.abrt", {31'd0, bus.abrt}, 32'd1);
        tick();
        chk("t4.abrt_once", {31'd0, bus.abrt}, 32'd0);
        send_byte(8'h55, 1'b0);
        chk("t4.dat",      {24'd0, bus.dat}, 32'h55);
        chk("t4.first",    {31'd0, bus.first}, 32'd1);
        chk("t4.ack",      {31'd0, bus.ack}, 32'd1);
        chk("t4.addr_hit", {31'd0, bus.addr_hit}, 32'd0);

        // START coincident with an SCL sample mid-byte
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        bus.sta      = 1'b1;
        bus.scl_lohi = 1'b1;
        bus.sda      = 1'b1;
        tick();
        bus.sta      = 1'b0;
        bus.scl_lohi = 1'b0;
        chk("t5.abrt", {31'd0, bus.abrt}, 32'd1);
        bus.rdy = 1'b0;
        send_byte(8'h0F, 1'b0);
        chk("t5.dat",   {24'd0, bus.dat}, 32'h0F);
        chk("t5.first", {31'd0, bus.first}, 32'd1);
        chk("t5.vld",   {31'd0, bus.vld}, 32'd1);

        // reset asserted during bit 5 of the next byte
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus.sda      = 1'b1;
        bus.scl_lohi = 1'b1;
        rst_n        = 1'b0;
        tick();
        bus.scl_lohi = 1'b0;
        chk_all_zero("t5.rst");
        rst_n   = 1'b1;
        bus.rdy = 1'b1;
        tick();
        vld_seen = 0;
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b0);
            if (bus.vld) vld_seen++;
        end
        chk("t5.idle_vld", vld_seen, 32'd0);
        chk("t5.idle_abrt", {31'd0, bus.abrt}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL timeout: got no finish, required finish before 200000ns");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
